// File: rtl/bias_loader.sv
// rtl/bias_loader.sv - shadow-buffered bias word loader with atomic commit
//
// Purpose: accepts T = N_G_L2+N_G_L3+N_D_L2+N_D_L3 bias words over a
// valid/ready stream into shadow slots, then copies all slots to the output
// registers in a single COMMIT cycle so a partial load is never visible.
// Optional feature macro: BIAS_LOADER_CHECKSUM_EN - each load carries one
// extra trailing word holding the WIDTH-bit wrap-around sum of the data
// words; a mismatch sets the sticky err flag and skips the commit.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          single-cycle load request (honoured only in IDLE)
//   abort          cancels a load in LOAD/CHECK
//   in_valid       in_data holds a valid word
//   in_data        signed Q8.24 bias word
//   in_ready       high while in LOAD
//   bg2/bg3/bd2/bd3 committed bias vectors, element 0 in the LSBs
//   busy           load in progress (LOAD, CHECK, COMMIT)
//   done           one-cycle pulse when a load commits
//   err            sticky checksum mismatch flag (0 without the macro)

module bias_loader #(
    parameter int WIDTH  = 32,
    parameter int N_G_L2 = 3,
    parameter int N_G_L3 = 9,
    parameter int N_D_L2 = 3,
    parameter int N_D_L3 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic [N_G_L2*WIDTH-1:0]  bg2,
    output logic [N_G_L3*WIDTH-1:0]  bg3,
    output logic [N_D_L2*WIDTH-1:0]  bd2,
    output logic [N_D_L3*WIDTH-1:0]  bd3,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int T  = N_G_L2 + N_G_L3 + N_D_L2 + N_D_L3;
    // Counter must hold T itself: in checksum mode it sits at T while the
    // checksum word is awaited.
    localparam int CW = $clog2(T + 1);
    localparam logic [CW-1:0] LAST_C = CW'(T - 1);
`ifdef BIAS_LOADER_CHECKSUM_EN
    localparam logic [CW-1:0] T_C    = CW'(T);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [T*WIDTH-1:0]   shadow_q, shadow_d;
    logic [T*WIDTH-1:0]   out_q, out_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 xfer;
`ifdef BIAS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic [WIDTH-1:0]     chk_q, chk_d;
    logic                 err_q, err_d;
`endif

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        done_d   = 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        chk_d    = chk_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
`ifdef BIAS_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                // abort wins over a word arriving in the same cycle
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                    if (cnt_q == T_C) begin
                        chk_d   = in_data;
                        state_d = CHECK;
                    end else begin
                        for (int i = 0; i < T; i++) begin
                            if (cnt_q == CW'(i)) shadow_d[i*WIDTH +: WIDTH] = in_data;
                        end
                        sum_d = sum_q + in_data;
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    for (int i = 0; i < T; i++) begin
                        if (cnt_q == CW'(i)) shadow_d[i*WIDTH +: WIDTH] = in_data;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_C) state_d = COMMIT;
`endif
                end
            end
            CHECK: begin
`ifdef BIAS_LOADER_CHECKSUM_EN
                if (abort) begin
                    state_d = IDLE;
                end else if (chk_q == sum_q) begin
                    state_d = COMMIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                out_d   = shadow_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            out_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BIAS_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bg2      = out_q[0 +: N_G_L2*WIDTH];
    assign bg3      = out_q[N_G_L2*WIDTH +: N_G_L3*WIDTH];
    assign bd2      = out_q[(N_G_L2+N_G_L3)*WIDTH +: N_D_L2*WIDTH];
    assign bd3      = out_q[(N_G_L2+N_G_L3+N_D_L2)*WIDTH +: N_D_L3*WIDTH];
`ifdef BIAS_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
